// File: rtl/axi_r_buffer_pkg.sv
// Shared AXI R-channel definitions: response encodings and packed-beat sizing
// helpers used by axi_r_buffer.
package axi_r_buffer_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  localparam int unsigned RESP_WIDTH = 2;
  localparam int unsigned MAX_DEPTH  = 16;

  // A beat is stored as {user, id, resp, data, last}.
  function automatic int unsigned r_beat_width(input int unsigned id_w,
                                               input int unsigned data_w,
                                               input int unsigned user_w);
    return user_w + id_w + RESP_WIDTH + data_w + 1;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi_r_buffer.sv
// AXI R-channel elastic buffer: circular FIFO of BUFFER_DEPTH packed beats.
// Optional zero-latency bypass when empty: define AXI_R_BUFFER_FALLTHROUGH_EN.
module axi_r_buffer
  import axi_r_buffer_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned USER_WIDTH   = 6,
  parameter int unsigned BUFFER_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  master_valid_i,
  input  logic [DATA_WIDTH-1:0] master_data_i,
  input  logic [1:0]            master_resp_i,
  input  logic [ID_WIDTH-1:0]   master_id_i,
  input  logic [USER_WIDTH-1:0] master_user_i,
  input  logic                  master_last_i,
  output logic                  master_ready_o,
  output logic                  slave_valid_o,
  output logic [DATA_WIDTH-1:0] slave_data_o,
  output logic [1:0]            slave_resp_o,
  output logic [ID_WIDTH-1:0]   slave_id_o,
  output logic [USER_WIDTH-1:0] slave_user_o,
  output logic                  slave_last_o,
  input  logic                  slave_ready_i
);

  localparam int unsigned BEAT_W   = r_beat_width(ID_WIDTH, DATA_WIDTH, USER_WIDTH);
  localparam int unsigned PTR_W    = ptr_width(BUFFER_DEPTH);
  localparam int unsigned CNT_W    = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned DATA_LSB = 1;
  localparam int unsigned RESP_LSB = DATA_LSB + DATA_WIDTH;
  localparam int unsigned ID_LSB   = RESP_LSB + RESP_WIDTH;
  localparam int unsigned USER_LSB = ID_LSB + ID_WIDTH;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

  // Handshake: a beat moves on a side only in a cycle where valid and ready are
  // both high at the rising edge; valid never waits on ready, and the input-side
  // ready depends only on occupancy, never on slave_ready_i.

  logic [BEAT_W-1:0] mem_q [BUFFER_DEPTH];
  logic [BEAT_W-1:0] mem_d [BUFFER_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [BEAT_W-1:0] beat_in;
  logic [BEAT_W-1:0] beat_head;
  logic [BEAT_W-1:0] beat_out;
  logic              fifo_empty;
  logic              fifo_full;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              unused_test_en;

  assign unused_test_en = test_en_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign beat_in    = {master_user_i, master_id_i, master_resp_i, master_data_i, master_last_i};
  assign beat_head  = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  assign master_ready_o = ~fifo_full;

`ifdef AXI_R_BUFFER_FALLTHROUGH_EN
  // Empty buffer presents the incoming beat directly; if it is taken in the
  // same cycle it never touches the storage array.
  assign bypass        = fifo_empty & master_valid_i & slave_ready_i;
  assign slave_valid_o = ~fifo_empty | master_valid_i;
  assign beat_out      = fifo_empty ? beat_in : beat_head;
`else
  assign bypass        = 1'b0;
  assign slave_valid_o = ~fifo_empty;
  assign beat_out      = beat_head;
`endif

  assign push = master_valid_i & master_ready_o & ~bypass;
  assign pop  = ~fifo_empty & slave_ready_i;

  assign slave_last_o = beat_out[0];
  assign slave_data_o = beat_out[RESP_LSB-1:DATA_LSB];
  assign slave_resp_o = beat_out[ID_LSB-1:RESP_LSB];
  assign slave_id_o   = beat_out[USER_LSB-1:ID_LSB];
  assign slave_user_o = beat_out[BEAT_W-1:USER_LSB];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = beat_in;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; outputs are don't-care while empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= FULL_CNT);
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

endmodule
